// File: rtl/acc_collector.sv
// acc_collector: runs an upstream accumulate controller NUM_RUNS times per
// batch and queues every captured result in a small output FIFO.
module acc_collector #(
    parameter int DW       = 32,
    parameter int DEPTH    = 4,
    parameter int NUM_RUNS = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   go_i,
    output logic                   busy_o,
    output logic                   batch_done_o,
    output logic                   start_o,
    input  logic                   done_i,
    input  logic [DW-1:0]          acc_i,
    output logic [DW-1:0]          data_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int RW = (NUM_RUNS > 1) ? $clog2(NUM_RUNS) : 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [RW-1:0] LAST_RUN = RW'(NUM_RUNS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE,
        STORE
    } state_t;

    state_t        state;
    logic [RW-1:0] run;
    logic [DW-1:0] hold;
    logic          done_q;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          push;
    logic          pop;
    logic          last;

    // Full check looks only at the registered level, so a pop frees the
    // slot one cycle before the stalled store can use it.
    assign full         = (level_o == FULL_LVL);
    assign push         = (state == STORE) && !full;
    assign valid_o      = (level_o != '0);
    assign pop          = valid_o && ready_i;
    assign last         = (run == LAST_RUN);
    assign batch_done_o = push && last;
    assign data_o       = mem[rd_ptr];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            run     <= '0;
            hold    <= '0;
            done_q  <= 1'b0;
            start_o <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            done_q <= done_i;
            unique case (state)
                IDLE: begin
                    if (go_i) begin
                        run     <= '0;
                        state   <= LAUNCH;
                        start_o <= 1'b1;
                        busy_o  <= 1'b1;
                    end
                end
                LAUNCH: begin
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // A done level already high on entry is not a new result.
                    if (done_i && !done_q) begin
                        hold    <= acc_i;
                        state   <= STORE;
                        start_o <= 1'b0;
                    end
                end
                STORE: begin
                    if (!full) begin
                        if (last) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            run     <= run + 1'b1;
                            state   <= LAUNCH;
                            start_o <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_o <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= hold;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level_o <= level_o + 1'b1;
            end else if (pop && !push) begin
                level_o <= level_o - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_acc_collector.sv
// tb_acc_collector: directed bench for acc_collector with a behavioural
// upstream controller and a cycle-by-cycle vector table.
module tb_acc_collector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        go_a, done_a, ready_a, busy_a, bd_a, start_a, valid_a;
    logic [31:0] acc_a, data_a;
    logic [2:0]  level_a;

    logic        go_b, done_b, ready_b, busy_b, bd_b, start_b, valid_b;
    logic [31:0] acc_b, data_b;
    logic [2:0]  level_b;

    acc_collector #(.DW(32), .DEPTH(4), .NUM_RUNS(4)) u_a (
        .clk_i(clk), .rst_i(rst), .go_i(go_a), .busy_o(busy_a),
        .batch_done_o(bd_a), .start_o(start_a), .done_i(done_a),
        .acc_i(acc_a), .data_o(data_a), .valid_o(valid_a),
        .ready_i(ready_a), .level_o(level_a)
    );

    acc_collector #(.DW(32), .DEPTH(4), .NUM_RUNS(6)) u_b (
        .clk_i(clk), .rst_i(rst), .go_i(go_b), .busy_o(busy_b),
        .batch_done_o(bd_b), .start_o(start_b), .done_i(done_b),
        .acc_i(acc_b), .data_o(data_b), .valid_o(valid_b),
        .ready_i(ready_b), .level_o(level_b)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Upstream controller model: one-cycle done pulse two cycles after start rises
    int vals_a[8] = '{10, 20, 30, 40, 50, 60, 70, 80};
    int vals_b[6] = '{101, 102, 103, 104, 105, 106};
    int idx_a = 0, idx_b = 0, cnt_a = 0, cnt_b = 0;
    logic sp_a = 1'b0, sp_b = 1'b0;
    logic auto_a = 1'b1, auto_b = 1'b1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (auto_a) begin
                done_a = 1'b0;
                if (cnt_a > 0) begin
                    cnt_a--;
                    if (cnt_a == 0) begin
                        done_a = 1'b1;
                        acc_a = vals_a[idx_a % 8];
                        idx_a++;
                    end
                end
                if (start_a && !sp_a) cnt_a = 2;
            end else begin
                cnt_a = 0;
            end
            sp_a = start_a;
            if (auto_b) begin
                done_b = 1'b0;
                if (cnt_b > 0) begin
                    cnt_b--;
                    if (cnt_b == 0) begin
                        done_b = 1'b1;
                        acc_b = vals_b[idx_b % 6];
                        idx_b++;
                    end
                end
                if (start_b && !sp_b) cnt_b = 2;
            end else begin
                cnt_b = 0;
            end
            sp_b = start_b;
        end
    end

    // Output monitor: popped words, start rises, batch_done pulses
    logic [31:0] q_a[$], q_b[$];
    int rises_a = 0, rises_b = 0, bdc_a = 0, bdc_b = 0;
    logic stp_a = 1'b0, stp_b = 1'b0;

    always @(negedge clk) begin
        if (valid_a && ready_a) q_a.push_back(data_a);
        if (valid_b && ready_b) q_b.push_back(data_b);
        if (start_a && !stp_a) rises_a++;
        if (start_b && !stp_b) rises_b++;
        if (bd_a) bdc_a++;
        if (bd_b) bdc_b++;
        stp_a = start_a;
        stp_b = start_b;
    end

    typedef struct {
        logic        go;
        logic        done;
        logic [31:0] acc;
        logic        ready;
        logic        start;
        logic        busy;
        logic [2:0]  level;
        logic        valid;
        logic [31:0] data;
    } vec_t;

    vec_t tv[19];

    task automatic row(input int k, input int go, input int dn, input int acc,
                       input int rdy, input int st, input int bz,
                       input int lvl, input int vld, input int dat);
        tv[k].go    = (go != 0);
        tv[k].done  = (dn != 0);
        tv[k].acc   = 32'(acc);
        tv[k].ready = (rdy != 0);
        tv[k].start = (st != 0);
        tv[k].busy  = (bz != 0);
        tv[k].level = 3'(lvl);
        tv[k].valid = (vld != 0);
        tv[k].data  = 32'(dat);
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, "_a_busy"}, 32'(busy_a), 0);
        chk({tag, "_a_start"}, 32'(start_a), 0);
        chk({tag, "_a_bdone"}, 32'(bd_a), 0);
        chk({tag, "_a_valid"}, 32'(valid_a), 0);
        chk({tag, "_a_level"}, 32'(level_a), 0);
        chk({tag, "_a_data"}, data_a, 0);
    endtask

    task automatic chk_zero_b(input string tag);
        chk({tag, "_b_busy"}, 32'(busy_b), 0);
        chk({tag, "_b_start"}, 32'(start_b), 0);
        chk({tag, "_b_bdone"}, 32'(bd_b), 0);
        chk({tag, "_b_valid"}, 32'(valid_b), 0);
        chk({tag, "_b_level"}, 32'(level_b), 0);
        chk({tag, "_b_data"}, data_b, 0);
    endtask

    task automatic run_batch_a(input string tag, input int first,
                               input bit poke);
        int n;
        @(posedge clk);
        #1;
        q_a.delete();
        rises_a = 0;
        bdc_a = 0;
        idx_a = first;
        go_a = 1'b1;
        @(posedge clk);
        #1;
        go_a = 1'b0;
        if (poke) begin
            // instance is in WAIT_DONE here; this go must be ignored
            @(posedge clk);
            #1;
            go_a = 1'b1;
            @(posedge clk);
            #1;
            go_a = 1'b0;
        end
        n = 0;
        while (busy_a && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_finished"}, 32'(busy_a), 0);
        repeat (4) @(negedge clk);
        chk({tag, "_words"}, 32'(q_a.size()), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_word%0d", tag, i),
                (i < q_a.size()) ? q_a[i] : 32'hdead_beef,
                32'(vals_a[first + i]));
        end
        chk({tag, "_start_rises"}, 32'(rises_a), 4);
        chk({tag, "_batch_done"}, 32'(bdc_a), 1);
        chk({tag, "_busy_after"}, 32'(busy_a), 0);
        chk({tag, "_level_after"}, 32'(level_a), 0);
    endtask

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1;
        go_a = 1'b0;
        done_a = 1'b0;
        acc_a = '0;
        ready_a = 1'b1;
        go_b = 1'b0;
        done_b = 1'b0;
        acc_b = '0;
        ready_b = 1'b0;

        // go, done, acc, ready | start, busy, level, valid, data
        row(0,  1, 1, 111, 0,  0, 0, 0, 0, 0);
        row(1,  0, 1, 111, 0,  1, 1, 0, 0, 0);
        row(2,  0, 1, 222, 0,  1, 1, 0, 0, 0);
        row(3,  0, 1, 222, 0,  1, 1, 0, 0, 0);
        row(4,  0, 1, 222, 0,  1, 1, 0, 0, 0);
        row(5,  0, 0, 333, 0,  1, 1, 0, 0, 0);
        row(6,  0, 1, 444, 0,  1, 1, 0, 0, 0);
        row(7,  0, 0, 555, 0,  0, 1, 0, 0, 0);
        row(8,  0, 0, 555, 0,  1, 1, 1, 1, 444);
        row(9,  0, 0, 555, 0,  1, 1, 1, 1, 444);
        row(10, 0, 1, 666, 0,  1, 1, 1, 1, 444);
        row(11, 0, 0, 0,   0,  0, 1, 1, 1, 444);
        row(12, 0, 0, 0,   0,  1, 1, 2, 1, 444);
        row(13, 0, 0, 0,   0,  1, 1, 2, 1, 444);
        row(14, 0, 1, 777, 0,  1, 1, 2, 1, 444);
        row(15, 0, 0, 0,   1,  0, 1, 2, 1, 444);
        row(16, 0, 0, 0,   0,  1, 1, 2, 1, 666);
        row(17, 0, 0, 0,   1,  1, 1, 2, 1, 666);
        row(18, 0, 0, 0,   0,  1, 1, 1, 1, 777);

        #12;
        chk_zero_a("por");
        chk_zero_b("por");
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_batch_a("batch1", 0, 1'b0);
        run_batch_a("go_in_wait", 4, 1'b1);

        // manual done edges, then a push and pop in the same cycle at level 2
        @(negedge clk);
        auto_a = 1'b0;
        ready_a = 1'b0;
        for (int k = 0; k < 19; k++) begin
            @(posedge clk);
            #1;
            go_a = tv[k].go;
            done_a = tv[k].done;
            acc_a = tv[k].acc;
            ready_a = tv[k].ready;
            @(negedge clk);
            chk($sformatf("v%0d_start", k), 32'(start_a), 32'(tv[k].start));
            chk($sformatf("v%0d_busy", k), 32'(busy_a), 32'(tv[k].busy));
            chk($sformatf("v%0d_level", k), 32'(level_a), 32'(tv[k].level));
            chk($sformatf("v%0d_valid", k), 32'(valid_a), 32'(tv[k].valid));
            if (tv[k].valid)
                chk($sformatf("v%0d_data", k), data_a, tv[k].data);
        end

        // asynchronous abort with a word still queued
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_zero_a("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        rises_a = 0;
        bdc_a = 0;
        q_a.delete();
        ready_a = 1'b1;
        done_a = 1'b1;
        acc_a = 999;
        @(posedge clk);
        #1;
        done_a = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_busy", 32'(busy_a), 0);
        chk("post_rst_start", 32'(start_a), 0);
        chk("post_rst_rises", 32'(rises_a), 0);
        chk("post_rst_level", 32'(level_a), 0);
        chk("post_rst_popped", 32'(q_a.size()), 0);
        auto_a = 1'b1;
        run_batch_a("restart", 0, 1'b0);

        // instance B: full FIFO stalls the batch in STORE
        @(posedge clk);
        #1;
        q_b.delete();
        rises_b = 0;
        bdc_b = 0;
        idx_b = 0;
        ready_b = 1'b0;
        go_b = 1'b1;
        @(posedge clk);
        #1;
        go_b = 1'b0;
        n = 0;
        while (level_b != 3'd4 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        chk("stall_level", 32'(level_b), 4);
        chk("stall_start", 32'(start_b), 0);
        chk("stall_busy", 32'(busy_b), 1);
        chk("stall_launches", 32'(rises_b), 5);
        chk("stall_popped", 32'(q_b.size()), 0);
        chk("stall_bdone", 32'(bdc_b), 0);
        @(posedge clk);
        #1;
        ready_b = 1'b1;
        @(posedge clk);
        #1;
        ready_b = 1'b0;
        @(negedge clk);
        chk("pop1_level", 32'(level_b), 3);
        chk("pop1_start", 32'(start_b), 0);
        @(negedge clk);
        chk("refill_level", 32'(level_b), 4);
        chk("refill_start", 32'(start_b), 1);
        chk("pop1_count", 32'(q_b.size()), 1);
        chk("pop1_word", (q_b.size() > 0) ? q_b[0] : 32'hdead_beef, 101);
        repeat (10) @(negedge clk);
        chk("stall2_level", 32'(level_b), 4);
        chk("stall2_start", 32'(start_b), 0);
        chk("stall2_launches", 32'(rises_b), 6);
        @(posedge clk);
        #1;
        ready_b = 1'b1;
        n = 0;
        while (busy_b && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        chk("drain_busy", 32'(busy_b), 0);
        chk("drain_level", 32'(level_b), 0);
        chk("drain_words", 32'(q_b.size()), 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("drain_word%0d", i),
                (i < q_b.size()) ? q_b[i] : 32'hdead_beef, 32'(vals_b[i]));
        end
        chk("drain_bdone", 32'(bdc_b), 1);
        chk("drain_launches", 32'(rises_b), 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
